axis_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit AXI-Stream sink (the single-beat TREADY-toggling stream slave) between NUM_SRC stream masters.
- Has a one-entry registered output stage, so the M_* outputs are registered.
- Each accepted beat is tagged with its source index.
- Sits between the producer masters and the shared stream slave.

---
 rtl/axis_rr_arbiter.sv | 104 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI-Stream output between NUM_SRC masters.
// Define AXIS_ARB_PKT_LOCK_EN to hold the grant for a whole packet (S_TLAST/M_TLAST ports).
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      ACLK,
  input  logic                      ARSTN,
  input  logic [NUM_SRC-1:0]        S_TVALID,
  input  logic [NUM_SRC*DATA_W-1:0] S_TDATA,
  output logic [NUM_SRC-1:0]        S_TREADY,
`ifdef AXIS_ARB_PKT_LOCK_EN
  input  logic [NUM_SRC-1:0]        S_TLAST,
  output logic                      M_TLAST,
`endif
  output logic                      M_TVALID,
  output logic [DATA_W-1:0]         M_TDATA,
  input  logic                      M_TREADY,
  output logic [ID_W-1:0]           GRANT_ID,
  output logic [15:0]               BEAT_CNT
);

  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic [NUM_SRC-1:0] eligible;
  logic               found;
  logic               out_free;
  logic               accept;
  logic               drain;

  // The output register can take a new beat when empty or when it drains this cycle.
  assign drain    = M_TVALID && M_TREADY;
  assign out_free = !M_TVALID || M_TREADY;
  assign accept   = |(S_TVALID & S_TREADY);

`ifdef AXIS_ARB_PKT_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  state_t state, state_nxt;

  always_ff @(posedge ACLK) begin
    if (!ARSTN) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = S_TLAST[grant_idx] ? ST_IDLE : ST_LOCKED;
  end

  // While locked, last_grant is the packet owner; the search wraps back onto it.
  always_comb begin
    eligible = S_TVALID;
    if (state == ST_LOCKED) eligible = S_TVALID & (NUM_SRC'(1) << last_grant);
  end
`else
  assign eligible = S_TVALID;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    S_TREADY  = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_SRC);
      if (!found && eligible[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (ARSTN && out_free && found) S_TREADY[grant_idx] = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!ARSTN) begin
      M_TVALID   <= 1'b0;
      M_TDATA    <= '0;
      GRANT_ID   <= '0;
      BEAT_CNT   <= '0;
      last_grant <= ID_W'(NUM_SRC - 1);
`ifdef AXIS_ARB_PKT_LOCK_EN
      M_TLAST    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        M_TVALID   <= 1'b1;
        M_TDATA    <= S_TDATA[int'(grant_idx)*DATA_W +: DATA_W];
        GRANT_ID   <= grant_idx;
        last_grant <= grant_idx;
`ifdef AXIS_ARB_PKT_LOCK_EN
        M_TLAST    <= S_TLAST[grant_idx];
`endif
      end else if (drain) begin
        M_TVALID <= 1'b0;
      end
      if (drain && BEAT_CNT != 16'hFFFF) BEAT_CNT <= BEAT_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (NUM_SRC=4, DATA_W=32).
// Packet-lock scenario runs only when AXIS_ARB_PKT_LOCK_EN is defined.
module tb_axis_rr_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic                      ACLK;
  logic                      ARSTN;
  logic [NUM_SRC-1:0]        S_TVALID;
  logic [NUM_SRC*DATA_W-1:0] S_TDATA;
  logic [NUM_SRC-1:0]        S_TREADY;
  logic                      M_TVALID;
  logic [DATA_W-1:0]         M_TDATA;
  logic                      M_TREADY;
  logic [ID_W-1:0]           GRANT_ID;
  logic [15:0]               BEAT_CNT;
`ifdef AXIS_ARB_PKT_LOCK_EN
  logic [NUM_SRC-1:0]        S_TLAST;
  logic                      M_TLAST;
`endif

  int n_checks = 0;
  int n_errors = 0;

  axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .ACLK     (ACLK),
    .ARSTN    (ARSTN),
    .S_TVALID (S_TVALID),
    .S_TDATA  (S_TDATA),
    .S_TREADY (S_TREADY),
`ifdef AXIS_ARB_PKT_LOCK_EN
    .S_TLAST  (S_TLAST),
    .M_TLAST  (M_TLAST),
`endif
    .M_TVALID (M_TVALID),
    .M_TDATA  (M_TDATA),
    .M_TREADY (M_TREADY),
    .GRANT_ID (GRANT_ID),
    .BEAT_CNT (BEAT_CNT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance one rising edge, then step clear of it before driving or sampling.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARSTN    = 1'b0;
    S_TVALID = 4'hF;
    M_TREADY = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) S_TDATA[k*DATA_W +: DATA_W] = 32'hA000_0000 + k;
    tick();
    tick();
    n_checks++; if (S_TREADY !== 4'b0000) begin n_errors++; $display("FAIL reset_s_tready: got %b want 0000", S_TREADY); end
    n_checks++; if (M_TVALID !== 1'b0) begin n_errors++; $display("FAIL reset_m_tvalid: got %b want 0", M_TVALID); end
    n_checks++; if (M_TDATA !== 32'h0) begin n_errors++; $display("FAIL reset_m_tdata: got %h want 0", M_TDATA); end
    n_checks++; if (GRANT_ID !== 2'd0) begin n_errors++; $display("FAIL reset_grant_id: got %0d want 0", GRANT_ID); end
    n_checks++; if (BEAT_CNT !== 16'd0) begin n_errors++; $display("FAIL reset_beat_cnt: got %0d want 0", BEAT_CNT); end
    ARSTN = 1'b1;
    #1;
    n_checks++; if (S_TREADY !== 4'b0001) begin n_errors++; $display("FAIL first_grant: got %b want 0001", S_TREADY); end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] exp_data;
    logic [ID_W-1:0]   exp_id;
    logic [3:0]        exp_rdy;
    for (int j = 0; j < 5; j++) begin
      tick();
      exp_id   = ID_W'(j % 4);
      exp_data = 32'hA000_0000 + (j % 4);
      exp_rdy  = 4'b0001 << ((j + 1) % 4);
      n_checks++; if (M_TVALID !== 1'b1) begin n_errors++; $display("FAIL rr_valid[%0d]: got %b want 1", j, M_TVALID); end
      n_checks++; if (M_TDATA !== exp_data) begin n_errors++; $display("FAIL rr_data[%0d]: got %h want %h", j, M_TDATA, exp_data); end
      n_checks++; if (GRANT_ID !== exp_id) begin n_errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", j, GRANT_ID, exp_id); end
      n_checks++; if (S_TREADY !== exp_rdy) begin n_errors++; $display("FAIL rr_ready[%0d]: got %b want %b", j, S_TREADY, exp_rdy); end
    end
    n_checks++; if (BEAT_CNT !== 16'd4) begin n_errors++; $display("FAIL rr_beat_cnt: got %0d want 4", BEAT_CNT); end
    S_TVALID = 4'b0000;
    tick();
    n_checks++; if (M_TVALID !== 1'b0) begin n_errors++; $display("FAIL rr_drain_valid: got %b want 0", M_TVALID); end
    n_checks++; if (BEAT_CNT !== 16'd5) begin n_errors++; $display("FAIL rr_drain_cnt: got %0d want 5", BEAT_CNT); end
    n_checks++; if (M_TDATA !== 32'hA000_0000) begin n_errors++; $display("FAIL rr_drain_hold: got %h want a0000000", M_TDATA); end
  endtask

  task automatic test_backpressure();
    S_TDATA[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    S_TVALID = 4'b0100;
    M_TREADY = 1'b0;
    #1;
    n_checks++; if (S_TREADY !== 4'b0100) begin n_errors++; $display("FAIL bp_grant: got %b want 0100", S_TREADY); end
    tick();
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (M_TVALID !== 1'b1) begin n_errors++; $display("FAIL bp_valid[%0d]: got %b want 1", j, M_TVALID); end
      n_checks++; if (M_TDATA !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL bp_data[%0d]: got %h want deadbeef", j, M_TDATA); end
      n_checks++; if (GRANT_ID !== 2'd2) begin n_errors++; $display("FAIL bp_grant_id[%0d]: got %0d want 2", j, GRANT_ID); end
      n_checks++; if (S_TREADY !== 4'b0000) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", j, S_TREADY); end
      n_checks++; if (BEAT_CNT !== 16'd5) begin n_errors++; $display("FAIL bp_cnt[%0d]: got %0d want 5", j, BEAT_CNT); end
      if (j < 2) tick();
    end
    S_TVALID = 4'b0000;
    tick();  // third stall edge
    M_TREADY = 1'b1;
    tick();
    n_checks++; if (M_TVALID !== 1'b0) begin n_errors++; $display("FAIL bp_drained: got %b want 0", M_TVALID); end
    n_checks++; if (BEAT_CNT !== 16'd6) begin n_errors++; $display("FAIL bp_cnt_after: got %0d want 6", BEAT_CNT); end
    tick();
    n_checks++; if (BEAT_CNT !== 16'd6) begin n_errors++; $display("FAIL bp_delivered_once: got %0d want 6", BEAT_CNT); end
  endtask

  task automatic test_skip();
    S_TDATA[1*DATA_W +: DATA_W] = 32'hB1B1_B1B1;
    S_TDATA[3*DATA_W +: DATA_W] = 32'hB3B3_B3B3;
    S_TVALID = 4'b0010;
    tick();  // source 1 accepted, last_grant becomes 1
    S_TVALID = 4'b1010;
    #1;
    n_checks++; if (S_TREADY !== 4'b1000) begin n_errors++; $display("FAIL skip_ready3: got %b want 1000", S_TREADY); end
    tick();
    n_checks++; if (GRANT_ID !== 2'd3) begin n_errors++; $display("FAIL skip_grant3: got %0d want 3", GRANT_ID); end
    n_checks++; if (M_TDATA !== 32'hB3B3_B3B3) begin n_errors++; $display("FAIL skip_data3: got %h want b3b3b3b3", M_TDATA); end
    n_checks++; if (S_TREADY !== 4'b0010) begin n_errors++; $display("FAIL skip_ready1: got %b want 0010", S_TREADY); end
    tick();
    n_checks++; if (GRANT_ID !== 2'd1) begin n_errors++; $display("FAIL skip_grant1: got %0d want 1", GRANT_ID); end
    S_TVALID = 4'b0000;
    tick();
    n_checks++; if (BEAT_CNT !== 16'd9) begin n_errors++; $display("FAIL skip_cnt: got %0d want 9", BEAT_CNT); end
  endtask

  task automatic test_reset_mid();
    S_TDATA[0 +: DATA_W] = 32'hC0C0_C0C0;
    S_TVALID = 4'b0001;
    M_TREADY = 1'b0;
    tick();
    n_checks++; if (M_TVALID !== 1'b1) begin n_errors++; $display("FAIL mid_held: got %b want 1", M_TVALID); end
    S_TVALID = 4'b0000;
    ARSTN    = 1'b0;
    tick();
    n_checks++; if (M_TVALID !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b want 0", M_TVALID); end
    n_checks++; if (BEAT_CNT !== 16'd0) begin n_errors++; $display("FAIL mid_cnt: got %0d want 0", BEAT_CNT); end
    ARSTN    = 1'b1;
    M_TREADY = 1'b1;
    tick();
    tick();
    n_checks++; if (M_TVALID !== 1'b0) begin n_errors++; $display("FAIL mid_no_redeliver: got %b want 0", M_TVALID); end
    n_checks++; if (BEAT_CNT !== 16'd0) begin n_errors++; $display("FAIL mid_cnt_after: got %0d want 0", BEAT_CNT); end
  endtask

`ifdef AXIS_ARB_PKT_LOCK_EN
  task automatic test_pkt_lock();
    logic [ID_W-1:0] exp_id [4];
    logic            exp_last [4];
    exp_id   = '{2'd0, 2'd0, 2'd0, 2'd1};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0};
    S_TDATA[1*DATA_W +: DATA_W] = 32'hD1D1_D1D1;
    S_TVALID = 4'b0011;
    S_TLAST  = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      S_TDATA[0 +: DATA_W] = 32'hD000_0000 + j;
      if (j == 2) S_TLAST = 4'b0001;
      if (j == 3) begin S_TVALID = 4'b0010; S_TLAST = 4'b0000; end
      #1;
      if (j == 1 || j == 2) begin
        n_checks++; if (S_TREADY !== 4'b0001) begin n_errors++; $display("FAIL lock_ready[%0d]: got %b want 0001", j, S_TREADY); end
      end
      tick();
      n_checks++; if (GRANT_ID !== exp_id[j]) begin n_errors++; $display("FAIL lock_grant[%0d]: got %0d want %0d", j, GRANT_ID, exp_id[j]); end
      n_checks++; if (M_TLAST !== exp_last[j]) begin n_errors++; $display("FAIL lock_tlast[%0d]: got %b want %b", j, M_TLAST, exp_last[j]); end
    end
    S_TVALID = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    ARSTN    = 1'b0;
    S_TVALID = '0;
    S_TDATA  = '0;
    M_TREADY = 1'b0;
`ifdef AXIS_ARB_PKT_LOCK_EN
    S_TLAST  = '0;
`endif
    test_reset();
    test_round_robin();
    test_backpressure();
    test_skip();
    test_reset_mid();
`ifdef AXIS_ARB_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
